// File: rtl/maxnet_pkg.sv
// Shared constants and types for the Maxnet winner-take-all datapath.
package maxnet_pkg;

    localparam int DATA_W    = 32;
    localparam int N         = 4;
    localparam int NUM_WORDS = N + N * N;
    localparam int WCNT_W    = $clog2(NUM_WORDS);

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_LOAD  = 2'd1,
        LD_START = 2'd2,
        LD_BUSY  = 2'd3
    } ld_state_t;

endpackage : maxnet_pkg

// File: rtl/maxnet_word_buf.sv
// Frame buffer: indexed single-word writes, whole frame presented in parallel.
module maxnet_word_buf #(
    parameter int DATA_W = 32,
    parameter int N      = 4,
    parameter int IDX_W  = $clog2(N + N * N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_W-1:0]       wdata,
    output logic [N*DATA_W-1:0]     x_flat,
    output logic [N*N*DATA_W-1:0]   w_flat
);

    localparam int FRAME_WORDS = N + N * N;

    logic [DATA_W-1:0] mem_q [FRAME_WORDS];
    logic [DATA_W-1:0] mem_d [FRAME_WORDS];

    // Next-state of the buffer: only the addressed word changes on a write.
    always_comb begin
        for (int i = 0; i < FRAME_WORDS; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we && (idx < IDX_W'(FRAME_WORDS))) begin
            mem_d[idx] = wdata;
        end else begin
            mem_d[0] = mem_q[0];
        end
    end

    // Buffer storage, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FRAME_WORDS; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < FRAME_WORDS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Words 0..N-1 are the activations, the rest are the weights.
    for (genvar g = 0; g < N; g++) begin : g_x
        assign x_flat[g*DATA_W +: DATA_W] = mem_q[g];
    end
    for (genvar g = 0; g < N * N; g++) begin : g_w
        assign w_flat[g*DATA_W +: DATA_W] = mem_q[N + g];
    end

endmodule : maxnet_word_buf

// File: rtl/maxnet_input_loader.sv
// Maxnet input loader: captures one X/W frame from a valid/ready stream,
// announces it with a start pulse and holds it until the consumer is done.
module maxnet_input_loader #(
    parameter int DATA_W = maxnet_pkg::DATA_W,
    parameter int N      = maxnet_pkg::N
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    output logic [N*DATA_W-1:0]     x_flat,
    output logic [N*N*DATA_W-1:0]   w_flat,
    output logic                    start,
    output logic                    busy,
    input  logic                    cons_done,
    output logic                    frame_err
);

    import maxnet_pkg::*;

    localparam int FRAME_WORDS = N + N * N;
    localparam int CNT_W       = $clog2(FRAME_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_WORDS - 1);

    ld_state_t        state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             in_ready_q, in_ready_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             frame_err_q, frame_err_d;
    logic             xfer_s;
    logic             we_s;
    logic             err_s;

    assign xfer_s = in_valid & in_ready_q;

    // Frame FSM: counts accepted words and validates the in_last position.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        we_s    = 1'b0;
        err_s   = 1'b0;
        case (state_q)
            LD_IDLE: begin
                if (xfer_s && in_last) begin
                    err_s  = 1'b1;
                    wcnt_d = {CNT_W{1'b0}};
                end else if (xfer_s) begin
                    we_s    = 1'b1;
                    wcnt_d  = CNT_W'(1);
                    state_d = LD_LOAD;
                end else begin
                    state_d = LD_IDLE;
                end
            end
            LD_LOAD: begin
                if (xfer_s && (wcnt_q == LAST_IDX) && in_last) begin
                    we_s    = 1'b1;
                    wcnt_d  = {CNT_W{1'b0}};
                    state_d = LD_START;
                end else if (xfer_s && ((wcnt_q == LAST_IDX) || in_last)) begin
                    err_s   = 1'b1;
                    wcnt_d  = {CNT_W{1'b0}};
                    state_d = LD_IDLE;
                end else if (xfer_s) begin
                    we_s   = 1'b1;
                    wcnt_d = wcnt_q + CNT_W'(1);
                end else begin
                    state_d = LD_LOAD;
                end
            end
            LD_START: begin
                state_d = LD_BUSY;
            end
            LD_BUSY: begin
                if (cons_done) begin
                    state_d = LD_IDLE;
                end else begin
                    state_d = LD_BUSY;
                end
            end
            default: begin
                state_d = LD_IDLE;
                wcnt_d  = {CNT_W{1'b0}};
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered.
    always_comb begin
        in_ready_d  = (state_d == LD_IDLE) || (state_d == LD_LOAD);
        start_d     = (state_d == LD_START);
        busy_d      = (state_d == LD_START) || (state_d == LD_BUSY);
        frame_err_d = err_s;
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LD_IDLE;
            wcnt_q      <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            in_ready_q  <= in_ready_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign start     = start_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

    maxnet_word_buf #(
        .DATA_W (DATA_W),
        .N      (N),
        .IDX_W  (CNT_W)
    ) u_word_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we_s),
        .idx    (wcnt_q),
        .wdata  (in_data),
        .x_flat (x_flat),
        .w_flat (w_flat)
    );

endmodule : maxnet_input_loader

// File: doc/maxnet_input_loader.md
# maxnet_input_loader

Upstream stage of the Maxnet winner-take-all datapath. Accepts one frame of 20 32-bit words over a valid/ready stream: 4 initial activations X followed by 16 weights W. Buffers the frame and presents it in parallel to the 4-PU datapath. Pulses `start` to the controller and holds the buffer stable until the controller reports the iteration has finished.

## Interface
Parameters:
- `DATA_W`, 32, word width. Words are opaque to this block and are never interpreted arithmetically.
- `N`, 4, number of neurons/PUs. The frame length is `N + N*N` = 20.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_data`  in  DATA_W  stream word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a word.
- `in_last`  in  1  marks the final word of the frame.
- `x_flat`  out  N*DATA_W  X[i] at bits [i*DATA_W +: DATA_W].
- `w_flat`  out  N*N*DATA_W  W[k] at bits [k*DATA_W +: DATA_W]. W[4p..4p+3] feed PU p.
- `start`  out  1  one-cycle pulse: frame complete, consumer may load X.
- `busy`  out  1  buffer is owned by the consumer.
- `cons_done`  in  1  consumer finished (driven from the controller's `is_finished`/done).
- `frame_err`  out  1  one-cycle pulse on a framing error.

## Operation
- States: IDLE, LOAD, START, BUSY.
- Word counter `wcnt` is 5 bits, range 0..19.
- A transfer occurs when `in_valid & in_ready`.
  - Word j writes X[j] for j in 0..3, and W[j-4] for j in 4..19.
- IDLE → LOAD on the first transfer. The first word is written and `wcnt` becomes 1.
- LOAD: each transfer writes and increments `wcnt`.
  - Transfer at `wcnt`=19 with `in_last`=1: word is written, `wcnt` goes to 0, state goes to START.
  - Transfer with `in_last`=1 at `wcnt`<19 (early last): word is discarded, `frame_err` pulses, `wcnt` goes to 0, state goes to IDLE.
  - Transfer at `wcnt`=19 with `in_last`=0 (missing last): word is discarded, `frame_err` pulses, `wcnt` goes to 0, state goes to IDLE.
- In IDLE, a transfer with `in_last`=1 (one-word frame) is an early-last error.
- START: `start`=1 for exactly one cycle, then BUSY. `cons_done` is ignored in START.
- BUSY: `x_flat`/`w_flat` are frozen. When `cons_done`=1 is sampled, the next state is IDLE.
- `in_ready` = 1 in IDLE and LOAD, 0 in START and BUSY.
- `busy` = 1 in START and BUSY.
- Buffer contents are guaranteed to be a complete frame only while `busy`=1. After an error, partially overwritten contents are don't-care.

## Timing
- Reset values: state IDLE; `wcnt` 0; buffer all 0; `in_ready` 0; `start` 0; `busy` 0; `frame_err` 0.
- `in_ready` is registered. It rises on the first rising edge after `rst_n` deasserts.
- `rst_n` asserted mid-frame or mid-BUSY clears everything immediately, with no `start` or `frame_err` pulse.
- Latency: from the edge accepting word 19, the next cycle has `start`=1 and `in_ready`=0.
- From `cons_done`=1 sampled in BUSY, the next cycle has `busy`=0 and `in_ready`=1.
  - Minimum gap between the last word of one frame and the first of the next is 3 cycles: START, BUSY, then IDLE.
- `frame_err` asserts the cycle after the offending transfer. `in_ready` stays 1 throughout error handling.
- Back-to-back transfers: one word per cycle is sustained, so a frame takes 20 cycles with `in_valid` held high.
- `in_valid` low stalls without penalty. `wcnt` holds its value.
- All outputs are registered and contain no combinational path from any input.

## Structure
- Shared package `maxnet_pkg` contains:
  - `DATA_W`, `N`, and `NUM_WORDS` = N+N*N.
  - Counter width `WCNT_W` = $clog2(NUM_WORDS).
  - State encoding `ld_state_t` {IDLE, LOAD, START, BUSY}.
- One sub-module is natural: `maxnet_word_buf`.
  - Holds NUM_WORDS×DATA_W indexed-write registers.
  - Has write enable and index inputs, and drives the flat X/W outputs.
- The FSM and counter stay in the top module.

## Test plan
- Reset, then 20 words 0x1..0x14, `in_valid` continuous, `in_last` on word 20 → `x_flat` holds 0x1..0x4 and W[0]=0x5..W[15]=0x14. `start` pulses 1 cycle after the last transfer, then `busy`=1 and `in_ready`=0.
- With the buffer in BUSY, drive `in_valid`=1 with 0xDEAD for 10 cycles, then `cons_done`=1 for 1 cycle → no transfers occur and outputs are unchanged. `busy`=0 and `in_ready`=1 on the next cycle.
- `in_last`=1 on word 7 → `frame_err` pulses once and no `start` follows. A correct frame sent next loads cleanly.
- Word 20 sent with `in_last`=0 → `frame_err` pulses and no `start`. The next word is accepted as word 0.
- Random `in_valid` gaps (30% idle) over 5 back-to-back frames with a `cons_done` 4 cycles after each `start` → each frame is captured exactly, and `start` count equals 5.
- `rst_n` pulsed low mid-frame (after word 9) and again during BUSY → immediate return to reset values with no `start` or `frame_err`. The next full frame loads correctly.
